io_port_bank: RTL and testbench

Parametrised successor to the single write-only IO latch in the computer top. It provides NUM_PORTS bidirectional ports of WIDTH bits each, with per-bit direction control, synchronised pin readback, falling-edge interrupt flags and a masked IRQ output. It sits on the CPU bus in the system clock domain. It is decoded by the top like the VDP: read and write strobes are already qualified with the CPU clock low phase and the chip select.

---
 rtl/io_port_bank.sv | 80 ++++++++
 tb/tb_io_port_bank.sv | 123 ++++++++++++
 2 files changed

// File: rtl/io_port_bank.sv
// io_port_bank: NUM_PORTS x WIDTH bidirectional IO ports with synchronised readback.
// Define IO_PORT_BANK_IRQ_EN to build falling-edge flags, interrupt masks and irq.
module io_port_bank #(
  parameter int NUM_PORTS = 2,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 addr,
  input  logic                       read,
  input  logic                       write,
  input  logic [7:0]                 data_in,
  output logic [7:0]                 data_out,
  input  logic [NUM_PORTS*WIDTH-1:0] pins_in,
  output logic [NUM_PORTS*WIDTH-1:0] pins_out,
  output logic [NUM_PORTS*WIDTH-1:0] pins_oe,
  output logic                       irq
);
  localparam int N = NUM_PORTS * WIDTH;
  logic [N-1:0] out_r, ddr_r, sync_meta, sync_in, iflag, imask;
  logic [NUM_PORTS-1:0] hit;
  logic [WIDTH-1:0] rd_val;
  assign pins_out = out_r;
  assign pins_oe = ddr_r;
  always_comb begin
    hit = '0;
    rd_val = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hit[p] = addr[3:2] == 2'(p);
      if (hit[p])
        rd_val = addr[1:0] == 2'd0 ? (out_r[p*WIDTH +: WIDTH] & ddr_r[p*WIDTH +: WIDTH]) |
                                     (sync_in[p*WIDTH +: WIDTH] & ~ddr_r[p*WIDTH +: WIDTH]) :
                 addr[1:0] == 2'd1 ? ddr_r[p*WIDTH +: WIDTH] :
                 addr[1:0] == 2'd2 ? iflag[p*WIDTH +: WIDTH] : imask[p*WIDTH +: WIDTH];
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      out_r <= '0;
      ddr_r <= '0;
      sync_meta <= '0;
      sync_in <= '0;
      data_out <= '0;
    end else begin
      sync_meta <= pins_in;
      sync_in <= sync_meta;
      if (read && !write) data_out <= 8'(rd_val);
      for (int p = 0; p < NUM_PORTS; p++)
        if (write && hit[p]) begin
          if (addr[1:0] == 2'd0) out_r[p*WIDTH +: WIDTH] <= data_in[WIDTH-1:0];
          if (addr[1:0] == 2'd1) ddr_r[p*WIDTH +: WIDTH] <= data_in[WIDTH-1:0];
        end
    end
`ifdef IO_PORT_BANK_IRQ_EN
  logic [N-1:0] prev_in, clr;
  always_comb begin
    clr = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      clr[p*WIDTH +: WIDTH] = write && hit[p] && addr[1:0] == 2'd2 ? data_in[WIDTH-1:0] : '0;
  end
  // a new falling edge outranks a simultaneous write-1-to-clear
  always_ff @(posedge clk)
    if (!reset) begin
      prev_in <= '0;
      iflag <= '0;
      imask <= '0;
      irq <= 1'b0;
    end else begin
      prev_in <= sync_in;
      iflag <= (iflag & ~clr) | (prev_in & ~sync_in & ~ddr_r);
      irq <= |(iflag & imask);
      for (int p = 0; p < NUM_PORTS; p++)
        if (write && hit[p] && addr[1:0] == 2'd3) imask[p*WIDTH +: WIDTH] <= data_in[WIDTH-1:0];
    end
`else
  assign iflag = '0;
  assign imask = '0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: directed and random checks of io_port_bank against a behavioural model.
module tb_io_port_bank;
  localparam int NP = 2;
`ifdef IO_PORT_BANK_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, read = 1'b0, write = 1'b0, irq;
  logic [3:0] addr = '0;
  logic [7:0] data_in = '0, data_out;
  logic [15:0] pins_in = '0, pins_out, pins_oe;
  int n_chk = 0, n_pass = 0;
  logic [15:0] m_out, m_ddr, m_flag, m_mask, h0, h1, h2, pv;
  logic [7:0] m_dout;
  logic m_irq;
  io_port_bank #(.NUM_PORTS(NP), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .read(read), .write(write),
    .data_in(data_in), .data_out(data_out), .pins_in(pins_in),
    .pins_out(pins_out), .pins_oe(pins_oe), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic cyc(input logic rs, input logic r, input logic w, input logic [3:0] a,
                     input logic [7:0] d, input logic [15:0] pins);
    logic [15:0] fall, clr;
    logic [7:0] rd;
    int p;
    @(negedge clk);
    reset = rs; read = r; write = w; addr = a; data_in = d; pins_in = pins;
    @(posedge clk);
    p = int'(a[3:2]);
    if (!rs) begin
      {m_out, m_ddr, m_flag, m_mask, h0, h1, h2} = '0;
      m_dout = '0;
      m_irq = 1'b0;
    end else begin
      rd = '0;
      if (p < NP)
        case (a[1:0])
          2'd0: rd = (m_out[p*8 +: 8] & m_ddr[p*8 +: 8]) | (h1[p*8 +: 8] & ~m_ddr[p*8 +: 8]);
          2'd1: rd = m_ddr[p*8 +: 8];
          2'd2: rd = m_flag[p*8 +: 8];
          default: rd = m_mask[p*8 +: 8];
        endcase
      fall = h2 & ~h1 & ~m_ddr;
      clr = '0;
      if (r && !w) m_dout = rd;
      m_irq = |(m_flag & m_mask);
      if (w && p < NP)
        case (a[1:0])
          2'd0: m_out[p*8 +: 8] = d;
          2'd1: m_ddr[p*8 +: 8] = d;
          2'd2: clr[p*8 +: 8] = d;
          default: if (IRQ_EN) m_mask[p*8 +: 8] = d;
        endcase
      if (IRQ_EN) m_flag = (m_flag & ~clr) | fall;
      h2 = h1; h1 = h0; h0 = pins;
    end
    #1;
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("pins_out", 32'(pins_out), 32'(m_out));
    chk("pins_oe", 32'(pins_oe), 32'(m_ddr));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask
  initial begin
    pv = '0;
    cyc(0, 1, 1, 4'h1, 8'hFF, pv);
    cyc(0, 0, 1, 4'h0, 8'hFF, pv);
    chk("rst_oe", 32'(pins_oe), 32'h0);
    chk("rst_out", 32'(pins_out), 32'h0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 0, 4'(i), 8'h00, pv);
      chk("rst_read", 32'(data_out), 32'h0);
    end
    pv = 16'h013C;
    cyc(1, 0, 1, 4'h1, 8'hF0, pv);
    cyc(1, 0, 1, 4'h0, 8'hA5, pv);
    cyc(1, 1, 0, 4'h0, 8'h00, pv);
    chk("data0", 32'(data_out), 32'hAC);
    chk("out0", 32'(pins_out[7:0]), 32'hA5);
    chk("oe0", 32'(pins_oe[7:0]), 32'hF0);
    cyc(1, 0, 1, 4'h7, 8'h01, pv);
    cyc(1, 0, 0, 4'h0, 8'h00, pv);
    pv[8] = 1'b0;
    cyc(1, 0, 0, 4'h0, 8'h00, pv);
    cyc(1, 0, 0, 4'h0, 8'h00, pv);
    cyc(1, 0, 0, 4'h0, 8'h00, pv);
    cyc(1, 1, 0, 4'h6, 8'h00, pv);
    chk("iflag1_set", 32'(data_out), IRQ_EN ? 32'h01 : 32'h0);
    chk("irq_set", 32'(irq), 32'(IRQ_EN));
    cyc(1, 0, 1, 4'h6, 8'h01, pv);
    cyc(1, 0, 0, 4'h0, 8'h00, pv);
    chk("irq_clr", 32'(irq), 32'h0);
    pv[8] = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 4'h0, 8'h00, pv);
    pv[8] = 1'b0;
    cyc(1, 0, 0, 4'h0, 8'h00, pv);
    cyc(1, 0, 0, 4'h0, 8'h00, pv);
    cyc(1, 0, 1, 4'h6, 8'h01, pv);
    cyc(1, 1, 0, 4'h6, 8'h00, pv);
    chk("set_wins", 32'(data_out), IRQ_EN ? 32'h01 : 32'h0);
    chk("set_wins_irq", 32'(irq), 32'(IRQ_EN));
    for (int i = 12; i < 16; i++) cyc(1, 0, 1, 4'(i), 8'hFF, pv);
    for (int i = 12; i < 16; i++) begin
      cyc(1, 1, 0, 4'(i), 8'h00, pv);
      chk("unused_port", 32'(data_out), 32'h0);
    end
    chk("unused_out", 32'(pins_out), 32'h00A5);
    chk("unused_oe", 32'(pins_oe), 32'h00F0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) pv = 16'($urandom);
      cyc($urandom_range(0, 149) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0,
          4'($urandom), 8'($urandom), pv);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
